switch_allocator: RTL and testbench

- Per-router wormhole switch allocator for the 3D-mesh router.
- Takes one route request per input port, as produced by that input's route computation unit, and allocates each output port to one input at a time with round-robin fairness.
- Holds each allocation until the packet's tail flit has crossed, and drives the crossbar select lines.
- Requests routed to DROP are sunk immediately and counted.

---
 rtl/switch_allocator.sv | 136 +++++++++++++
 tb/tb_switch_allocator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin FSM per output, held until the tail flit crosses.
// Requests for DROP are consumed immediately and tallied in a saturating counter.
module switch_allocator #(
    parameter int unsigned NUM_PORTS  = 7,
    parameter int unsigned PORT_W     = 3,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*PORT_W-1:0] req_port,
    input  logic [NUM_PORTS-1:0]        req_tail,
    input  logic [NUM_PORTS-1:0]        out_ready,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [NUM_PORTS-1:0]        xbar_valid,
    output logic [NUM_PORTS*PORT_W-1:0] xbar_sel,
    output logic [DROP_CNT_W-1:0]       drop_count
);

    typedef enum logic {StIdle, StLocked} state_e;

    localparam logic [PORT_W-1:0] DropPort = PORT_W'(7);
    localparam logic [PORT_W-1:0] LastPort = PORT_W'(NUM_PORTS - 1);

    state_e                state_q  [NUM_PORTS];
    logic [PORT_W-1:0]     owner_q  [NUM_PORTS];
    logic [PORT_W-1:0]     rr_ptr_q [NUM_PORTS];
    logic [DROP_CNT_W-1:0] drop_count_q;

    logic [PORT_W-1:0]    port_of  [NUM_PORTS];
    logic [NUM_PORTS-1:0] owner_oh [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand     [NUM_PORTS];
    logic [PORT_W-1:0]    win      [NUM_PORTS];
    logic [NUM_PORTS-1:0] busy;
    logic [NUM_PORTS-1:0] has_win;
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] xfer_tail;
    logic [NUM_PORTS-1:0] drop_req;
    logic [DROP_CNT_W:0]  drop_sum;

    always_comb begin : decode
        busy = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            port_of[i] = req_port[i*PORT_W +: PORT_W];
        end
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                owner_oh[o][i] = (state_q[o] == StLocked) && (owner_q[o] == PORT_W'(i));
            end
            busy = busy | owner_oh[o];
        end
    end

    // Round-robin: first candidate at or above rr_ptr, otherwise wrap to the lowest candidate.
    always_comb begin : arbitrate
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            has_win[o] = 1'b0;
            win[o]     = '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand[o][i] = req_valid[i] && (port_of[i] == PORT_W'(o)) && !busy[i];
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!has_win[o] && cand[o][i] && (PORT_W'(i) >= rr_ptr_q[o])) begin
                    has_win[o] = 1'b1;
                    win[o]     = PORT_W'(i);
                end
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!has_win[o] && cand[o][i]) begin
                    has_win[o] = 1'b1;
                    win[o]     = PORT_W'(i);
                end
            end
        end
    end

    always_comb begin : transfer
        grant     = '0;
        xbar_sel  = '0;
        xfer      = '0;
        xfer_tail = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            xfer[o]      = !rst && (|(owner_oh[o] & req_valid)) && out_ready[o];
            xfer_tail[o] = xfer[o] && (|(owner_oh[o] & req_tail));
            grant        = grant | (owner_oh[o] & {NUM_PORTS{xfer[o]}});
            if (state_q[o] == StLocked) begin
                xbar_sel[o*PORT_W +: PORT_W] = owner_q[o];
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            drop_req[i] = !rst && req_valid[i] && (port_of[i] == DropPort) && !busy[i];
        end
        grant      = grant | drop_req;
        xbar_valid = xfer;
    end

    // One extra bit of headroom catches overflow for the saturation clamp.
    always_comb begin : drop_add
        drop_sum = {1'b0, drop_count_q};
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            drop_sum = drop_sum + {{DROP_CNT_W{1'b0}}, drop_req[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= StIdle;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
            drop_count_q <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                unique case (state_q[o])
                    StIdle: begin
                        if (has_win[o]) begin
                            state_q[o]  <= StLocked;
                            owner_q[o]  <= win[o];
                            rr_ptr_q[o] <= (win[o] == LastPort) ? '0 : win[o] + 1'b1;
                        end
                    end
                    StLocked: begin
                        if (xfer_tail[o]) begin
                            state_q[o] <= StIdle;
                        end
                    end
                endcase
            end
            drop_count_q <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: single flit, round-robin, backpressure, parallel
// allocation, DROP counting with saturation, and mid-packet reset.
module tb_switch_allocator;

    localparam int N  = 7;
    localparam int PW = 3;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*PW-1:0]   req_port;
    logic [N-1:0]      req_tail;
    logic [N-1:0]      out_ready;
    logic [N-1:0]      grant;
    logic [N-1:0]      xbar_valid;
    logic [N*PW-1:0]   xbar_sel;
    logic [CW-1:0]     drop_count;

    int checks   = 0;
    int failures = 0;
    int rem [N];

    logic [6:0] rr_exp [12] = '{7'h00, 7'h02, 7'h02, 7'h00, 7'h08, 7'h08,
                                7'h00, 7'h20, 7'h20, 7'h00, 7'h02, 7'h02};
    logic       t3_rdy [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic       t3_vld [11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic [6:0] t3_exp [11] = '{7'h00, 7'h01, 7'h00, 7'h00, 7'h00, 7'h01,
                                7'h00, 7'h01, 7'h01, 7'h00, 7'h08};

    switch_allocator #(
        .NUM_PORTS (N),
        .PORT_W    (PW),
        .DROP_CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .xbar_valid(xbar_valid),
        .xbar_sel  (xbar_sel),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input int p, input bit t, input bit v);
        req_valid[i]          = v;
        req_port[i*PW +: PW]  = PW'(p);
        req_tail[i]           = t;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_port  = '0;
        req_tail  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = '1;
        clear_all();
        tick();
        // Reset gating: a DROP request must not grant while rst is high
        set_req(2, 7, 1'b1, 1'b1);
        settle();
        chk("rst_grant", grant, 0);
        chk("rst_xvalid", xbar_valid, 0);
        tick();
        rst = 1'b0;
        clear_all();
        settle();
        chk("init_drop", drop_count, 0);
        chk("init_grant", grant, 0);
        chk("init_xvalid", xbar_valid, 0);
        chk("init_xsel", xbar_sel, 0);

        // Single-flit EAST -> LOCAL
        set_req(1, 0, 1'b1, 1'b1);
        settle();
        chk("t1_arb_grant", grant, 0);
        tick();
        settle();
        chk("t1_grant", grant, 7'h02);
        chk("t1_xvalid", xbar_valid, 7'h01);
        chk("t1_xsel", xbar_sel, 1);
        tick();
        clear_all();
        settle();
        chk("t1_idle_xvalid", xbar_valid, 0);
        chk("t1_idle_xsel", xbar_sel, 0);
        chk("t1_idle_grant", grant, 0);

        // Round-robin on DOWN: input 1 sends two packets, 3 and 5 one each
        rem = '{0, 4, 0, 2, 0, 2, 0};
        tick();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] > 0) set_req(i, 6, (rem[i] % 2) == 1, 1'b1);
                else            set_req(i, 0, 1'b0, 1'b0);
            end
            settle();
            chk($sformatf("t2_grant_c%0d", c), grant, rr_exp[c]);
            chk($sformatf("t2_xvalid_c%0d", c), xbar_valid, (rr_exp[c] != 0) ? 7'h40 : 7'h00);
            for (int i = 0; i < N; i++) begin
                if (rr_exp[c][i]) begin
                    chk($sformatf("t2_xsel_c%0d", c), xbar_sel[6*PW +: PW], i);
                    rem[i]--;
                end
            end
            tick();
        end
        clear_all();
        settle();
        chk("t2_idle_grant", grant, 0);
        chk("t2_idle_xvalid", xbar_valid, 0);

        // Backpressure and bubble on 0 -> 2 while input 3 waits for the same output
        tick();
        rem[0] = 4;
        for (int c = 0; c < 11; c++) begin
            out_ready    = '1;
            out_ready[2] = t3_rdy[c];
            set_req(0, 2, rem[0] == 1, t3_vld[c] && (rem[0] > 0));
            set_req(3, 2, 1'b1, 1'b1);
            settle();
            chk($sformatf("t3_grant_c%0d", c), grant, t3_exp[c]);
            chk($sformatf("t3_xvalid_c%0d", c), xbar_valid, (t3_exp[c] != 0) ? 7'h04 : 7'h00);
            if (t3_exp[c][0]) rem[0]--;
            tick();
        end
        out_ready = '1;
        clear_all();
        chk("t3_flits_left", rem[0], 0);

        // Parallel non-conflicting allocations
        set_req(0, 1, 1'b1, 1'b1);
        set_req(2, 3, 1'b1, 1'b1);
        set_req(4, 5, 1'b1, 1'b1);
        settle();
        chk("t4_arb_grant", grant, 0);
        tick();
        settle();
        chk("t4_grant", grant, 7'h15);
        chk("t4_xvalid", xbar_valid, 7'h2A);
        chk("t4_xsel", xbar_sel, 21'h20400);
        tick();
        clear_all();
        settle();
        chk("t4_idle_xvalid", xbar_valid, 0);

        // DROP from inputs 2 and 4 for three cycles
        set_req(2, 7, 1'b0, 1'b1);
        set_req(4, 7, 1'b0, 1'b1);
        settle();
        chk("t5_grant0", grant, 7'h14);
        chk("t5_xvalid0", xbar_valid, 0);
        chk("t5_cnt0", drop_count, 0);
        tick();
        settle();
        chk("t5_grant1", grant, 7'h14);
        chk("t5_cnt1", drop_count, 2);
        tick();
        settle();
        chk("t5_grant2", grant, 7'h14);
        chk("t5_cnt2", drop_count, 4);
        tick();
        clear_all();
        settle();
        chk("t5_cnt3", drop_count, 6);
        chk("t5_idle_grant", grant, 0);

        // Reset during the second flit of a 5-flit packet on 1 -> 0
        set_req(1, 0, 1'b0, 1'b1);
        settle();
        chk("t6_arb_grant", grant, 0);
        tick();
        settle();
        chk("t6_flit1_grant", grant, 7'h02);
        tick();
        rst = 1'b1;
        settle();
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_xvalid", xbar_valid, 0);
        tick();
        rst = 1'b0;
        // Inputs 1 and 2 contend; only a cleared rr_ptr picks input 1 first
        set_req(1, 0, 1'b1, 1'b1);
        set_req(2, 0, 1'b1, 1'b1);
        settle();
        chk("t6_post_grant", grant, 0);
        chk("t6_post_xvalid", xbar_valid, 0);
        chk("t6_post_xsel", xbar_sel, 0);
        chk("t6_post_cnt", drop_count, 0);
        tick();
        settle();
        chk("t6_fresh_grant", grant, 7'h02);
        chk("t6_fresh_xsel", xbar_sel, 1);
        tick();
        set_req(1, 0, 1'b0, 1'b0);
        settle();
        chk("t6_rearb_grant", grant, 0);
        tick();
        settle();
        chk("t6_next_grant", grant, 7'h04);
        chk("t6_next_xsel", xbar_sel, 2);
        tick();
        clear_all();

        // Saturation: 9362 cycles of seven drops reach 0xFFFE
        for (int i = 0; i < N; i++) set_req(i, 7, 1'b0, 1'b1);
        settle();
        chk("t7_all_drop_grant", grant, 7'h7F);
        chk("t7_all_drop_xvalid", xbar_valid, 0);
        repeat (9362) tick();
        clear_all();
        set_req(2, 7, 1'b0, 1'b1);
        set_req(4, 7, 1'b0, 1'b1);
        settle();
        chk("t7_cnt_fffe", drop_count, 16'hFFFE);
        tick();
        for (int i = 0; i < N; i++) set_req(i, 7, 1'b0, 1'b1);
        settle();
        chk("t7_cnt_ffff", drop_count, 16'hFFFF);
        tick();
        clear_all();
        settle();
        chk("t7_cnt_hold", drop_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
